bp_me_bedrock_to_axi_dram: RTL and testbench
============================================

# bp_me_bedrock_to_axi_dram

Memory-side bridge from the BlackParrot BedRock memory stream to an AXI4 master port on the Zynq PS DRAM. It sits directly downstream of the unicore/multicore ZynqParrot processor: it consumes the 64-bit BedRock fill stream on `mem_fwd` and returns responses on `mem_rev`. It also rebases the 34-bit physical address into the 32-bit PS DRAM window. One transaction is outstanding at a time.

## Interface
- `paddr_width_p`, 34: BedRock physical address width.
- `axi_addr_width_p`, 32: AXI address width; the DRAM window is 2^axi_addr_width_p bytes.
- `data_width_p`, 64: BedRock fill width and AXI data width. Fixed at 64.
- `payload_width_p`, 16: opaque BedRock payload width, echoed unchanged.
- `dram_base_addr_p`, 34'h0_8000_0000: physical address that maps to AXI address 0.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `mem_fwd_msg_type_i` in 4: 0=rd, 1=wr, 2=uc_rd, 3=uc_wr. Other values are handled as reads.
- `mem_fwd_addr_i` in `paddr_width_p`: byte address.
- `mem_fwd_size_i` in 3: log2 of the byte count, 0..6 (1B..64B).
- `mem_fwd_payload_i` in `payload_width_p`: opaque.
- `mem_fwd_data_i` in 64, `mem_fwd_v_i` in 1, `mem_fwd_last_i` in 1, `mem_fwd_ready_and_o` out 1: forward stream. The header is stable for all beats of a message.
- `mem_rev_msg_type_o` out 4, `mem_rev_addr_o` out `paddr_width_p`, `mem_rev_size_o` out 3, `mem_rev_payload_o` out `payload_width_p`: the latched header.
- `mem_rev_data_o` out 64, `mem_rev_v_o` out 1, `mem_rev_last_o` out 1, `mem_rev_ready_and_i` in 1: reverse stream.
- AXI4 master: `m_axi_aw{addr,len,size,burst,valid,ready}`, `m_axi_w{data,strb,last,valid,ready}`, `m_axi_b{resp,valid,ready}`, `m_axi_ar{addr,len,size,burst,valid,ready}`, `m_axi_r{data,resp,last,valid,ready}`. Widths are addr 32, len 8, size 3, burst 2, data 64, strb 8, resp 2. ID is tied to 0.
- `error_o` out 1: sticky flag for an AXI error or an unmapped access.

## Operation
- FSM states: `e_ready`, `e_rd_addr`, `e_rd_data`, `e_wr`, `e_wr_resp`, `e_resp`.
- `e_ready`
  - `mem_fwd_ready_and_o` = 0. When `mem_fwd_v_i` is high, latch the header (peek; no beat is consumed).
  - Mapped means `dram_base_addr_p` <= addr < `dram_base_addr_p` + 2^`axi_addr_width_p`.
  - Mapped rd/uc_rd -> `e_rd_addr`. Mapped wr/uc_wr -> `e_wr`. Unmapped -> `e_resp`.
- Address translation: axi_addr = (addr − base)[31:0].
  - size >= 3: align down to 2^size, AxSIZE = 3, AxLEN = 2^(size−3) − 1, AxBURST = INCR (1).
  - size < 3: AxADDR = translated address aligned to 2^size, AxSIZE = size, AxLEN = 0.
- `e_rd_addr`
  - `m_axi_arvalid` = 1.
  - On the AR handshake, consume the single fwd beat (`mem_fwd_ready_and_o` pulses 1) and go to `e_rd_data`.
- `e_rd_data`: R passes through to rev combinationally.
  - `mem_rev_v_o` = rvalid, `m_axi_rready` = `mem_rev_ready_and_i`, `mem_rev_last_o` = rlast.
  - size < 3: the 2^size-byte field at offset addr[2:0] is replicated across 64 bits.
  - After the last-beat handshake -> `e_ready`.
- `e_wr`
  - `m_axi_awvalid` stays 1 until the AW handshake (tracked by an aw_done flag).
  - W is independent of AW: `m_axi_wvalid` = `mem_fwd_v_i`, `mem_fwd_ready_and_o` = wready, wdata = fwd data.
  - `m_axi_wlast` is generated from an internal beat counter reaching AxLEN; `mem_fwd_last_i` is not used.
  - wstrb: all ones for size >= 3; otherwise (2^(2^size) − 1) << addr[2:0].
  - When AW is done and the last W beat handshakes -> `e_wr_resp`.
- `e_wr_resp`: `m_axi_bready` = 1. On the B handshake -> `e_resp`.
- `e_resp`
  - One rev beat: data 0, `mem_rev_last_o` = 1.
  - Unmapped case: the fwd beats are drained first. `mem_fwd_ready_and_o` = 1 until `mem_fwd_last_i` handshakes, then `mem_rev_v_o` rises. No AXI activity.
  - -> `e_ready` after the rev handshake.
- `error_o` is set by rresp != 0 on any R beat, bresp != 0, or an unmapped access. It is cleared only by reset.
- Rev header outputs are the latched header during every rev beat.

## Timing
- Reset: state `e_ready`. All AXI valid and ready outputs 0, `mem_rev_v_o` 0, `mem_fwd_ready_and_o` 0, `error_o` 0, counters 0, header register 0.
- Reset mid-burst: outputs are in reset values the cycle after reset. The AXI slave is assumed reset concurrently.
- Fwd header seen in cycle 0 -> AR/AW valid in cycle 1.
- Read data has 0-cycle latency R -> rev (combinational passthrough).
- Write: the rev beat is valid the cycle after the B handshake.
- Valids, once asserted, hold with stable payload until the handshake. This is AXI- and BedRock-compliant.
- Back-to-back: the next header is sampled in the cycle after the final rev handshake (1 bubble).

## Test plan
- Read of 64B at 0x0_8000_1040 -> ARADDR 0x0000_1040, ARLEN 7, ARSIZE 3, ARBURST 1. Check 8 rev beats with data matching R, last only on the 8th, `error_o` 0.
- Write of 4B (uc_wr) at 0x0_8000_0004 with data 0xDEADBEEF_DEADBEEF -> AWADDR 4, AWLEN 0, AWSIZE 2, WSTRB 0xF0, WLAST 1. After BRESP 0, one rev beat with data 0.
- Read of 1B at 0x0_8000_0003 with RDATA 0x1122_3344_5566_7788 -> rev data 0x5555_5555_5555_5555.
- Read of 8B at 0x0_0010_0000 (unmapped) -> no AR issued. One rev beat with data 0, last 1, and `error_o` rises and stays 1.
- Write of 64B with AW ready delayed 10 cycles while W runs, and random `mem_rev_ready_and_i`/wready backpressure -> all 8 beats delivered in order, BRESP 2 sets `error_o`.
- Reset asserted during beat 3 of a 64B read -> next cycle the state is ready with all valids 0. A fresh 8B read then completes correctly.

Source files
------------

// File: rtl/bp_me_bedrock_to_axi_dram.sv
// BedRock memory stream to AXI4 master bridge onto the Zynq PS DRAM window.
// One transaction in flight; read data flows from R straight to the reverse stream.
module bp_me_bedrock_to_axi_dram
  #(parameter int paddr_width_p = 34,
    parameter int axi_addr_width_p = 32,
    parameter int data_width_p = 64,
    parameter int payload_width_p = 16,
    parameter logic [paddr_width_p-1:0] dram_base_addr_p = 34'h0_8000_0000)
  (input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [3:0]                    mem_fwd_msg_type_i,
   input  logic [paddr_width_p-1:0]      mem_fwd_addr_i,
   input  logic [2:0]                    mem_fwd_size_i,
   input  logic [payload_width_p-1:0]    mem_fwd_payload_i,
   input  logic [data_width_p-1:0]       mem_fwd_data_i,
   input  logic                          mem_fwd_v_i,
   input  logic                          mem_fwd_last_i,
   output logic                          mem_fwd_ready_and_o,
   output logic [3:0]                    mem_rev_msg_type_o,
   output logic [paddr_width_p-1:0]      mem_rev_addr_o,
   output logic [2:0]                    mem_rev_size_o,
   output logic [payload_width_p-1:0]    mem_rev_payload_o,
   output logic [data_width_p-1:0]       mem_rev_data_o,
   output logic                          mem_rev_v_o,
   output logic                          mem_rev_last_o,
   input  logic                          mem_rev_ready_and_i,
   output logic [axi_addr_width_p-1:0]   m_axi_awaddr,
   output logic [7:0]                    m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [data_width_p-1:0]       m_axi_wdata,
   output logic [data_width_p/8-1:0]     m_axi_wstrb,
   output logic                          m_axi_wlast,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [axi_addr_width_p-1:0]   m_axi_araddr,
   output logic [7:0]                    m_axi_arlen,
   output logic [2:0]                    m_axi_arsize,
   output logic [1:0]                    m_axi_arburst,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [data_width_p-1:0]       m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rlast,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   output logic                          error_o);

  localparam logic [2:0] e_ready   = 3'd0;
  localparam logic [2:0] e_rd_addr = 3'd1;
  localparam logic [2:0] e_rd_data = 3'd2;
  localparam logic [2:0] e_wr      = 3'd3;
  localparam logic [2:0] e_wr_resp = 3'd4;
  localparam logic [2:0] e_resp    = 3'd5;

  logic [2:0] state_r, state_n;
  logic [3:0] msg_type_r;
  logic [paddr_width_p-1:0] addr_r;
  logic [2:0] size_r;
  logic [payload_width_p-1:0] payload_r;
  logic unmapped_r, aw_done_r, w_done_r, drained_r, error_r;
  logic [7:0] beat_cnt_r;

  // The mapped window test is done on the live header, before it is latched.
  logic [paddr_width_p:0] fwd_offset;
  logic fwd_mapped, fwd_is_wr;
  assign fwd_offset = {1'b0, mem_fwd_addr_i} - {1'b0, dram_base_addr_p};
  assign fwd_mapped = (fwd_offset >> axi_addr_width_p) == '0;
  assign fwd_is_wr  = (mem_fwd_msg_type_i == 4'd1) || (mem_fwd_msg_type_i == 4'd3);

  logic [axi_addr_width_p-1:0] axi_base, ax_addr;
  logic [7:0] ax_len;
  logic [2:0] ax_size, byte_off;
  logic big;
  assign axi_base = addr_r[axi_addr_width_p-1:0] - dram_base_addr_p[axi_addr_width_p-1:0];
  assign ax_addr  = axi_base & ({axi_addr_width_p{1'b1}} << size_r);
  assign big      = size_r >= 3'd3;
  assign ax_len   = big ? ((8'd1 << (size_r - 3'd3)) - 8'd1) : 8'd0;
  assign ax_size  = big ? 3'd3 : size_r;
  assign byte_off = ax_addr[2:0];

  logic aw_hs, w_hs, r_hs, b_hs, drain_hs, beat_is_last;
  assign beat_is_last = beat_cnt_r == ax_len;
  assign aw_hs    = (state_r == e_wr) & ~aw_done_r & m_axi_awready;
  assign w_hs     = (state_r == e_wr) & ~w_done_r & mem_fwd_v_i & m_axi_wready;
  assign r_hs     = (state_r == e_rd_data) & m_axi_rvalid & mem_rev_ready_and_i;
  assign b_hs     = (state_r == e_wr_resp) & m_axi_bvalid;
  assign drain_hs = (state_r == e_resp) & unmapped_r & ~drained_r & mem_fwd_v_i & mem_fwd_last_i;

  // Narrow reads replicate the addressed field across the whole beat.
  logic [data_width_p-1:0] rd_repl;
  logic [7:0] strb_base;
  always_comb begin
    rd_repl   = m_axi_rdata;
    strb_base = 8'hFF;
    case (size_r)
      3'd0: begin rd_repl = {8{m_axi_rdata[{byte_off, 3'b000} +: 8]}};          strb_base = 8'h01; end
      3'd1: begin rd_repl = {4{m_axi_rdata[{byte_off[2:1], 4'b0000} +: 16]}};   strb_base = 8'h03; end
      3'd2: begin rd_repl = {2{m_axi_rdata[{byte_off[2], 5'b00000} +: 32]}};    strb_base = 8'h0F; end
      default: begin rd_repl = m_axi_rdata; strb_base = 8'hFF; end
    endcase
  end

  // Next state and per-state handshake outputs.
  always_comb begin
    state_n             = state_r;
    mem_fwd_ready_and_o = 1'b0;
    mem_rev_v_o         = 1'b0;
    mem_rev_last_o      = 1'b0;
    mem_rev_data_o      = '0;
    m_axi_arvalid       = 1'b0;
    m_axi_awvalid       = 1'b0;
    m_axi_wvalid        = 1'b0;
    m_axi_bready        = 1'b0;
    m_axi_rready        = 1'b0;
    case (state_r)
      e_ready: begin
        if (!mem_fwd_v_i) state_n = e_ready;
        else if (!fwd_mapped) state_n = e_resp;
        else if (fwd_is_wr) state_n = e_wr;
        else state_n = e_rd_addr;
      end
      e_rd_addr: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          mem_fwd_ready_and_o = 1'b1;
          state_n = e_rd_data;
        end else begin
          state_n = e_rd_addr;
        end
      end
      e_rd_data: begin
        mem_rev_v_o    = m_axi_rvalid;
        m_axi_rready   = mem_rev_ready_and_i;
        mem_rev_last_o = m_axi_rlast;
        mem_rev_data_o = rd_repl;
        if (r_hs && m_axi_rlast) state_n = e_ready;
        else state_n = e_rd_data;
      end
      e_wr: begin
        m_axi_awvalid       = ~aw_done_r;
        m_axi_wvalid        = mem_fwd_v_i & ~w_done_r;
        mem_fwd_ready_and_o = m_axi_wready & ~w_done_r;
        if ((aw_done_r || aw_hs) && (w_done_r || (w_hs && beat_is_last))) state_n = e_wr_resp;
        else state_n = e_wr;
      end
      e_wr_resp: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_n = e_resp;
        else state_n = e_wr_resp;
      end
      e_resp: begin
        if (unmapped_r && !drained_r) begin
          mem_fwd_ready_and_o = 1'b1;
          state_n = e_resp;
        end else begin
          mem_rev_v_o    = 1'b1;
          mem_rev_last_o = 1'b1;
          if (mem_rev_ready_and_i) state_n = e_ready;
          else state_n = e_resp;
        end
      end
      default: state_n = e_ready;
    endcase
  end

  // State, latched header, progress flags and the sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_ready;
      msg_type_r <= 4'd0;
      addr_r     <= '0;
      size_r     <= 3'd0;
      payload_r  <= '0;
      unmapped_r <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      drained_r  <= 1'b0;
      beat_cnt_r <= 8'd0;
      error_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      if (state_r == e_ready && mem_fwd_v_i) begin
        msg_type_r <= mem_fwd_msg_type_i;
        addr_r     <= mem_fwd_addr_i;
        size_r     <= mem_fwd_size_i;
        payload_r  <= mem_fwd_payload_i;
        unmapped_r <= ~fwd_mapped;
      end
      aw_done_r  <= (state_n == e_wr) && (aw_done_r || aw_hs);
      w_done_r   <= (state_n == e_wr) && (w_done_r || (w_hs && beat_is_last));
      beat_cnt_r <= (state_n == e_wr) ? beat_cnt_r + {7'd0, w_hs} : 8'd0;
      drained_r  <= (state_n == e_resp) && (drained_r || drain_hs);
      error_r    <= error_r | (r_hs & (m_axi_rresp != 2'd0)) | (b_hs & (m_axi_bresp != 2'd0))
                  | ((state_r == e_ready) & mem_fwd_v_i & ~fwd_mapped);
    end
  end

  assign mem_rev_msg_type_o = msg_type_r;
  assign mem_rev_addr_o     = addr_r;
  assign mem_rev_size_o     = size_r;
  assign mem_rev_payload_o  = payload_r;
  assign m_axi_awaddr  = ax_addr;
  assign m_axi_awlen   = ax_len;
  assign m_axi_awsize  = ax_size;
  assign m_axi_awburst = 2'b01;
  assign m_axi_araddr  = ax_addr;
  assign m_axi_arlen   = ax_len;
  assign m_axi_arsize  = ax_size;
  assign m_axi_arburst = 2'b01;
  assign m_axi_wdata   = mem_fwd_data_i;
  assign m_axi_wstrb   = big ? 8'hFF : (strb_base << byte_off);
  assign m_axi_wlast   = beat_is_last;
  assign error_o       = error_r;

endmodule

// File: tb/tb_bp_me_bedrock_to_axi_dram.sv
// Randomized bench for the BedRock-to-AXI DRAM bridge: the bench plays BedRock
// master and AXI slave, and predicts AXI requests and reverse beats from the address rules.
module tb_bp_me_bedrock_to_axi_dram;
  localparam logic [33:0] BASE = 34'h0_8000_0000;

  logic clk = 1'b0;
  logic reset_i;
  logic [3:0] mem_fwd_msg_type_i;
  logic [33:0] mem_fwd_addr_i;
  logic [2:0] mem_fwd_size_i;
  logic [15:0] mem_fwd_payload_i;
  logic [63:0] mem_fwd_data_i;
  logic mem_fwd_v_i, mem_fwd_last_i, mem_fwd_ready_and_o;
  logic [3:0] mem_rev_msg_type_o;
  logic [33:0] mem_rev_addr_o;
  logic [2:0] mem_rev_size_o;
  logic [15:0] mem_rev_payload_o;
  logic [63:0] mem_rev_data_o;
  logic mem_rev_v_o, mem_rev_last_o, mem_rev_ready_and_i;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen, m_axi_wstrb;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready, error_o;

  always #5 clk = ~clk;

  bp_me_bedrock_to_axi_dram dut (
    .clk_i(clk), .reset_i(reset_i),
    .mem_fwd_msg_type_i(mem_fwd_msg_type_i), .mem_fwd_addr_i(mem_fwd_addr_i),
    .mem_fwd_size_i(mem_fwd_size_i), .mem_fwd_payload_i(mem_fwd_payload_i),
    .mem_fwd_data_i(mem_fwd_data_i), .mem_fwd_v_i(mem_fwd_v_i),
    .mem_fwd_last_i(mem_fwd_last_i), .mem_fwd_ready_and_o(mem_fwd_ready_and_o),
    .mem_rev_msg_type_o(mem_rev_msg_type_o), .mem_rev_addr_o(mem_rev_addr_o),
    .mem_rev_size_o(mem_rev_size_o), .mem_rev_payload_o(mem_rev_payload_o),
    .mem_rev_data_o(mem_rev_data_o), .mem_rev_v_o(mem_rev_v_o),
    .mem_rev_last_o(mem_rev_last_o), .mem_rev_ready_and_i(mem_rev_ready_and_i),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .error_o(error_o));

  int n_chk = 0;
  int n_pass = 0;
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    mem_fwd_msg_type_i = 4'd0; mem_fwd_addr_i = 34'd0; mem_fwd_size_i = 3'd0;
    mem_fwd_payload_i = 16'd0; mem_fwd_data_i = 64'd0; mem_fwd_v_i = 1'b0; mem_fwd_last_i = 1'b0;
    mem_rev_ready_and_i = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bresp = 2'd0; m_axi_bvalid = 1'b0; m_axi_arready = 1'b0;
    m_axi_rdata = 64'd0; m_axi_rresp = 2'd0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  // Expected reverse data of a narrow read: the addressed field repeated across 64 bits.
  function automatic logic [63:0] repl(input logic [63:0] d, input int sz, input int off);
    logic [63:0] f, res;
    int w;
    if (sz >= 3) return d;
    w = 8 << sz;
    f = (d >> (8 * off)) & ((64'd1 << w) - 64'd1);
    res = 64'd0;
    for (int i = 0; i < 64; i += w) res |= f << i;
    return res;
  endfunction

  task automatic run_txn(input logic [3:0] mt, input logic [33:0] addr, input logic [2:0] size,
                         input int aw_delay, input bit bp, input logic [1:0] rr, input logic [1:0] br,
                         input bit use_fix, input logic [63:0] fix, input int abort_at);
    longint unsigned a, off, ea;
    bit is_wr, mapped, rd_m, done, aborted, b_done, r_taken, b_taken;
    bit ar_hs, aw_hs, w_hs, b_hs, r_hs, fwd_hs, rev_hs;
    int nb, nfwd, cyc, fi, wi, ri, revn, ar_n, aw_n, b_cyc;
    logic [7:0] estrb, elen;
    logic [2:0] esize;
    logic [15:0] pl;
    logic [63:0] fdat[$];

    a = 64'(addr);
    is_wr = (mt == 4'd1) || (mt == 4'd3);
    mapped = (a >= 64'(BASE)) && (a < 64'(BASE) + 64'h1_0000_0000);
    rd_m = mapped && !is_wr;
    off = (a - 64'(BASE)) & 64'hFFFF_FFFF;
    ea = off & ~((64'd1 << size) - 64'd1);
    nb = (size >= 3'd3) ? (1 << (int'(size) - 3)) : 1;
    elen = 8'(nb - 1);
    esize = (size >= 3'd3) ? 3'd3 : size;
    if (size >= 3'd3) estrb = 8'hFF;
    else estrb = 8'(((64'd1 << (1 << size)) - 64'd1) << (ea % 8));
    nfwd = is_wr ? nb : 1;
    pl = 16'($urandom);
    for (int i = 0; i < nfwd; i++) fdat.push_back(use_fix ? fix : {$urandom, $urandom});

    done = 0; aborted = 0; b_done = 0; r_taken = 0; b_taken = 0;
    cyc = 0; fi = 0; wi = 0; ri = 0; revn = 0; ar_n = 0; aw_n = 0; b_cyc = -10;
    while (!done && !aborted && cyc < 3000) begin
      @(negedge clk);
      mem_fwd_msg_type_i = mt; mem_fwd_addr_i = addr; mem_fwd_size_i = size; mem_fwd_payload_i = pl;
      mem_fwd_v_i = fi < nfwd;
      mem_fwd_data_i = (fi < nfwd) ? fdat[fi] : 64'd0;
      mem_fwd_last_i = fi == nfwd - 1;
      m_axi_arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_awready = cyc >= aw_delay;
      m_axi_wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rev_ready_and_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r_taken) begin m_axi_rvalid = 1'b0; r_taken = 0; end
      if (!m_axi_rvalid && ar_n > 0 && ri < nb && (!bp || $urandom_range(0, 1) == 1)) begin
        m_axi_rvalid = 1'b1; m_axi_rresp = rr; m_axi_rlast = ri == nb - 1;
        m_axi_rdata = use_fix ? fix : {$urandom, $urandom};
      end
      if (b_taken) begin m_axi_bvalid = 1'b0; b_taken = 0; end
      if (!m_axi_bvalid && !b_done && aw_n > 0 && wi == nb) begin
        m_axi_bvalid = 1'b1; m_axi_bresp = br;
      end
      #1;
      ar_hs = m_axi_arvalid && m_axi_arready;
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs = m_axi_wvalid && m_axi_wready;
      b_hs = m_axi_bvalid && m_axi_bready;
      r_hs = m_axi_rvalid && m_axi_rready;
      fwd_hs = mem_fwd_v_i && mem_fwd_ready_and_o;
      rev_hs = mem_rev_v_o && mem_rev_ready_and_i;
      if (cyc == 1 && mapped) chk("axvalid_cycle1", 64'(is_wr ? m_axi_awvalid : m_axi_arvalid), 64'd1);
      if (rd_m) chk("rev_v_passthru", 64'(mem_rev_v_o), 64'(m_axi_rvalid));
      if (b_done && cyc == b_cyc + 1) chk("rev_after_b", 64'(mem_rev_v_o), 64'd1);
      if (ar_hs) begin
        chk("araddr", 64'(m_axi_araddr), ea);
        chk("arlen_size_burst", {m_axi_arlen, m_axi_arsize, m_axi_arburst}, {elen, esize, 2'b01});
        ar_n++;
      end
      if (aw_hs) begin
        chk("awaddr", 64'(m_axi_awaddr), ea);
        chk("awlen_size_burst", {m_axi_awlen, m_axi_awsize, m_axi_awburst}, {elen, esize, 2'b01});
        aw_n++;
      end
      if (w_hs) begin
        chk("wdata", m_axi_wdata, (wi < nfwd) ? fdat[wi] : 64'd0);
        chk("wstrb_wlast", {m_axi_wstrb, m_axi_wlast}, {estrb, 1'(wi == nb - 1)});
        wi++;
      end
      if (rev_hs) begin
        chk("rev_hdr", {mem_rev_msg_type_o, mem_rev_size_o, mem_rev_payload_o, mem_rev_addr_o},
            {mt, size, pl, addr});
        if (rd_m) begin
          chk("rev_r_sync", 64'(r_hs), 64'd1);
          chk("rev_rd_data", mem_rev_data_o, repl(m_axi_rdata, int'(size), int'(ea % 8)));
          chk("rev_rd_last", 64'(mem_rev_last_o), 64'(ri == nb - 1));
          done = ri == nb - 1;
        end else begin
          chk("rev_resp", {mem_rev_data_o, mem_rev_last_o}, {64'd0, 1'b1});
          chk("rev_after_fwd", 64'(fi), 64'(nfwd));
          done = 1;
        end
        revn++;
        if (abort_at > 0 && revn == abort_at) aborted = 1;
      end
      if (b_hs) begin
        b_done = 1; b_cyc = cyc; b_taken = 1;
        if (br != 2'd0) err_exp = 1'b1;
      end
      if (r_hs) begin
        ri++; r_taken = 1;
        if (rr != 2'd0) err_exp = 1'b1;
      end
      if (fwd_hs) fi++;
      cyc++;
    end
    if (aborted) return;
    chk("txn_done", 64'(done), 64'd1);
    if (!mapped) err_exp = 1'b1;
    @(negedge clk);
    mem_fwd_v_i = 1'b0; m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
    #1;
    chk("error_o", 64'(error_o), 64'(err_exp));
    chk("idle", {m_axi_arvalid, m_axi_awvalid, mem_rev_v_o, mem_fwd_ready_and_o}, 64'd0);
    chk("ar_aw_count", {32'(ar_n), 32'(aw_n)}, {32'(rd_m), 32'(mapped && is_wr)});
    chk("w_fwd_count", {32'(wi), 32'(fi)}, {32'((mapped && is_wr) ? nb : 0), 32'(nfwd)});
  endtask

  task automatic reset_check(input string tag);
    chk(tag, {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready,
              mem_rev_v_o, mem_fwd_ready_and_o, error_o}, 64'd0);
  endtask

  logic [3:0] mt;
  logic [2:0] sz;
  logic [33:0] ad;
  logic [31:0] o32;
  int kind;

  initial begin
    reset_i = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    reset_check("reset_outputs");
    chk("reset_hdr", {mem_rev_msg_type_o, mem_rev_size_o, mem_rev_payload_o, mem_rev_addr_o}, 64'd0);
    reset_i = 1'b0;

    run_txn(4'd0, 34'h0_8000_1040, 3'd6, 0, 1'b0, 2'd0, 2'd0, 1'b0, 64'd0, 0);
    run_txn(4'd3, 34'h0_8000_0004, 3'd2, 0, 1'b0, 2'd0, 2'd0, 1'b1, 64'hDEADBEEF_DEADBEEF, 0);
    run_txn(4'd2, 34'h0_8000_0003, 3'd0, 0, 1'b0, 2'd0, 2'd0, 1'b1, 64'h1122_3344_5566_7788, 0);
    run_txn(4'd0, 34'h1_7FFF_FFF8, 3'd3, 0, 1'b1, 2'd0, 2'd0, 1'b0, 64'd0, 0);
    run_txn(4'd0, 34'h0_0010_0000, 3'd3, 0, 1'b0, 2'd0, 2'd0, 1'b0, 64'd0, 0);
    run_txn(4'd0, 34'h1_8000_0000, 3'd3, 0, 1'b0, 2'd0, 2'd0, 1'b0, 64'd0, 0);
    run_txn(4'd1, 34'h0_8000_0200, 3'd6, 10, 1'b1, 2'd0, 2'd2, 1'b0, 64'd0, 0);

    run_txn(4'd0, 34'h0_8000_2000, 3'd6, 0, 1'b0, 2'd0, 2'd0, 1'b0, 64'd0, 3);
    @(negedge clk);
    reset_i = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    reset_check("midburst_reset");
    reset_i = 1'b0;
    err_exp = 1'b0;
    run_txn(4'd0, 34'h0_8000_3008, 3'd3, 0, 1'b0, 2'd0, 2'd0, 1'b0, 64'd0, 0);

    for (int t = 0; t < 30; t++) begin
      mt = 4'($urandom_range(0, 5));
      sz = 3'($urandom_range(0, 6));
      kind = $urandom_range(0, 9);
      o32 = $urandom;
      if (kind == 0) ad = 34'($urandom_range(0, 32'h7FFF_FFFF));
      else if (kind == 1) ad = {2'b10, o32};
      else begin
        if (sz < 3'd3) o32 = o32 & ~((32'd1 << sz) - 32'd1);
        ad = BASE + {2'b00, o32};
      end
      run_txn(mt, ad, sz, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0, ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd0,
              1'b0, 64'd0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
